// File: rtl/cache_dest_enable_unit_pkg.sv
// Shared constants for the reference-block cache destination-enable logic:
// luma/chroma cache-block geometry and the default address/dimension widths.
package cache_dest_enable_unit_pkg;

  // Cache-block size in pixels. Chroma blocks are half the luma size, so one
  // grid index covers the same picture area in both components.
  localparam int C_L_H_SIZE   = 8;
  localparam int C_L_V_SIZE   = 8;
  localparam int C_L_H_SIZE_C = 4;
  localparam int C_L_V_SIZE_C = 4;

  localparam int C_SHIFT_L_H = $clog2(C_L_H_SIZE);
  localparam int C_SHIFT_L_V = $clog2(C_L_V_SIZE);
  localparam int C_SHIFT_C_H = $clog2(C_L_H_SIZE_C);
  localparam int C_SHIFT_C_V = $clog2(C_L_V_SIZE_C);

  localparam int C_NOW_X_WDTH    = 9;
  localparam int C_NOW_Y_WDTH    = 9;
  localparam int C_START_X_WDTH  = 11;
  localparam int C_START_Y_WDTH  = 11;
  localparam int C_XXMA_DIM_WDTH = 7;
  localparam int C_XXMA_DIM_HIGT = 7;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cache_dest_enable_unit_axis_range_hit.sv
// One-axis overlap test: does cache-block index addr_i fall inside the span of
// blocks touched by pixels [start_i, start_i + dim_i - 1]?
module axis_range_hit
  import cache_dest_enable_unit_pkg::*;
#(
  parameter int ADDR_WDTH  = C_NOW_X_WDTH,
  parameter int START_WDTH = C_START_X_WDTH,
  parameter int DIM_WDTH   = C_XXMA_DIM_WDTH,
  parameter int SHIFT      = C_SHIFT_L_H
) (
  input  logic [ADDR_WDTH-1:0]  addr_i,
  input  logic [START_WDTH-1:0] start_i,
  input  logic [DIM_WDTH-1:0]   dim_i,
  output logic                  hit_o
);

  // One extra bit keeps start + dim - 1 from wrapping at the top of the range.
  localparam int SUM_WDTH = max_int(START_WDTH, DIM_WDTH) + 1;
  localparam int CMP_WDTH = max_int(ADDR_WDTH, SUM_WDTH);

  logic [SUM_WDTH-1:0] start_ext;
  logic [SUM_WDTH-1:0] dim_ext;
  logic [SUM_WDTH-1:0] end_pix;
  logic [SUM_WDTH-1:0] first_idx;
  logic [SUM_WDTH-1:0] last_idx;
  logic [CMP_WDTH-1:0] addr_cmp;
  logic [CMP_WDTH-1:0] first_cmp;
  logic [CMP_WDTH-1:0] last_cmp;
  logic                dim_nz;

  assign start_ext = SUM_WDTH'(start_i);
  assign dim_ext   = SUM_WDTH'(dim_i);
  // end_pix underflows when dim is zero and start is zero; dim_nz masks that.
  assign end_pix   = start_ext + dim_ext - SUM_WDTH'(1);

  assign first_idx = start_ext >> SHIFT;
  assign last_idx  = end_pix >> SHIFT;

  assign addr_cmp  = CMP_WDTH'(addr_i);
  assign first_cmp = CMP_WDTH'(first_idx);
  assign last_cmp  = CMP_WDTH'(last_idx);

  assign dim_nz = (dim_i != '0);
  assign hit_o  = dim_nz && (addr_cmp >= first_cmp) && (addr_cmp <= last_cmp);

endmodule

// File: rtl/cache_dest_enable_unit.sv
// Flags whether cache block (x_addr, y_addr) intersects the destination
// reference block; combinational result plus a one-cycle registered copy.
module cache_dest_enable_unit
  import cache_dest_enable_unit_pkg::*;
#(
  parameter int NOW_X_WDTH    = C_NOW_X_WDTH,
  parameter int NOW_Y_WDTH    = C_NOW_Y_WDTH,
  parameter int START_X_WDTH  = C_START_X_WDTH,
  parameter int START_Y_WDTH  = C_START_Y_WDTH,
  parameter int XXMA_DIM_WDTH = C_XXMA_DIM_WDTH,
  parameter int XXMA_DIM_HIGT = C_XXMA_DIM_HIGT,
  parameter int SHIFT_H       = C_SHIFT_L_H,
  parameter int SHIFT_V       = C_SHIFT_L_V
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NOW_X_WDTH-1:0]    x_addr,
  input  logic [NOW_Y_WDTH-1:0]    y_addr,
  input  logic [START_X_WDTH-1:0]  start_x,
  input  logic [START_Y_WDTH-1:0]  start_y,
  input  logic [XXMA_DIM_WDTH-1:0] blk_width,
  input  logic [XXMA_DIM_HIGT-1:0] blk_height,
  output logic                     dest_enable,
  output logic                     dest_enable_r
);

  logic x_hit;
  logic y_hit;
  logic dest_enable_d;
  logic dest_enable_q;

  axis_range_hit #(
    .ADDR_WDTH  (NOW_X_WDTH),
    .START_WDTH (START_X_WDTH),
    .DIM_WDTH   (XXMA_DIM_WDTH),
    .SHIFT      (SHIFT_H)
  ) u_x_hit (
    .addr_i  (x_addr),
    .start_i (start_x),
    .dim_i   (blk_width),
    .hit_o   (x_hit)
  );

  axis_range_hit #(
    .ADDR_WDTH  (NOW_Y_WDTH),
    .START_WDTH (START_Y_WDTH),
    .DIM_WDTH   (XXMA_DIM_HIGT),
    .SHIFT      (SHIFT_V)
  ) u_y_hit (
    .addr_i  (y_addr),
    .start_i (start_y),
    .dim_i   (blk_height),
    .hit_o   (y_hit)
  );

  // Stays live through reset: the counters sample it in the same cycle.
  assign dest_enable_d = x_hit & y_hit;
  assign dest_enable   = dest_enable_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      dest_enable_q <= 1'b0;
    end else begin
      dest_enable_q <= dest_enable_d;
    end
  end

  assign dest_enable_r = dest_enable_q;

endmodule

// File: tb/tb_cache_dest_enable_unit.sv
// Self-checking bench for cache_dest_enable_unit with 4-pixel cache blocks.
module tb_cache_dest_enable_unit;

  localparam int SH  = 2;
  localparam int BLK = 1 << SH;

  logic        clk;
  logic        reset;
  logic [8:0]  x_addr;
  logic [8:0]  y_addr;
  logic [10:0] start_x;
  logic [10:0] start_y;
  logic [6:0]  blk_width;
  logic [6:0]  blk_height;
  logic        dest_enable;
  logic        dest_enable_r;

  logic        exp_q[$];
  logic        exp_r;
  int          n_vec;
  int          n_err;

  cache_dest_enable_unit #(
    .SHIFT_H (SH),
    .SHIFT_V (SH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .x_addr        (x_addr),
    .y_addr        (y_addr),
    .start_x       (start_x),
    .start_y       (start_y),
    .blk_width     (blk_width),
    .blk_height    (blk_height),
    .dest_enable   (dest_enable),
    .dest_enable_r (dest_enable_r)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: block b covers pixels [b*BLK, b*BLK+BLK-1]; overlap of two
  // closed pixel intervals, evaluated in wide integers.
  function automatic logic model(input longint x, input longint y,
                                 input longint sx, input longint sy,
                                 input longint w, input longint h);
    logic xh, yh;
    if (w == 0 || h == 0) return 1'b0;
    xh = (x * BLK <= sx + w - 1) && (sx <= x * BLK + BLK - 1);
    yh = (y * BLK <= sy + h - 1) && (sy <= y * BLK + BLK - 1);
    return xh && yh;
  endfunction

  // Expected registered output, following the inputs present at each edge.
  always @(posedge clk) begin
    exp_r <= reset ? 1'b0 : model(x_addr, y_addr, start_x, start_y, blk_width, blk_height);
  end

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Driver: apply inputs just after a rising edge and queue the expectation.
  task automatic drive(input logic [8:0] x, input logic [8:0] y,
                       input logic [10:0] sx, input logic [10:0] sy,
                       input logic [6:0] w, input logic [6:0] h, input logic rst);
    @(posedge clk);
    #1;
    x_addr = x; y_addr = y; start_x = sx; start_y = sy;
    blk_width = w; blk_height = h; reset = rst;
    exp_q.push_back(model(x, y, sx, sy, w, h));
  endtask

  // Scoreboard: pop and compare on the falling edge.
  task automatic sample(input string tag);
    logic e;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check_bit({tag, "_queue_empty"}, 1'b1, 1'b0);
    end else begin
      e = exp_q.pop_front();
      check_bit(tag, dest_enable, e);
    end
    check_bit({tag, "_r"}, dest_enable_r, exp_r);
  endtask

  task automatic vec(input string tag, input logic [8:0] x, input logic [8:0] y,
                     input logic [10:0] sx, input logic [10:0] sy,
                     input logic [6:0] w, input logic [6:0] h, input logic rst);
    drive(x, y, sx, sy, w, h, rst);
    sample(tag);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    x_addr = '0; y_addr = '0; start_x = '0; start_y = '0;
    blk_width = '0; blk_height = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_bit("reset_r", dest_enable_r, 1'b0);

    // X sweep: pixels 5..12 -> columns 1..3
    vec("xsweep0", 0, 0, 5, 0, 8, 4, 0);
    vec("xsweep1", 1, 0, 5, 0, 8, 4, 0);
    vec("xsweep2", 2, 0, 5, 0, 8, 4, 0);
    vec("xsweep3", 3, 0, 5, 0, 8, 4, 0);
    vec("xsweep4", 4, 0, 5, 0, 8, 4, 0);

    // Aligned edge: pixels 8..11 -> column 2 only
    vec("align2", 2, 0, 8, 0, 4, 4, 0);
    vec("align1", 1, 0, 8, 0, 4, 4, 0);
    vec("align3", 3, 0, 8, 0, 4, 4, 0);

    // Y gating: rows 3..4 -> block rows 0..1
    vec("ygate0", 1, 0, 4, 3, 4, 2, 0);
    vec("ygate1", 1, 1, 4, 3, 4, 2, 0);
    vec("ygate2", 1, 2, 4, 3, 4, 2, 0);

    // Degenerate sizes
    for (int x = 0; x < 6; x++) begin
      for (int y = 0; y < 3; y++) begin
        vec("zero_w", 9'(x), 9'(y), 0, 0, 0, 8, 0);
        vec("zero_h", 9'(x), 9'(y), 0, 0, 8, 0, 0);
      end
    end

    // Overflow: pixels 2047..2048 -> columns 511..512, no wrap
    vec("ovf_x0",   0,   0, 11'h7FF, 0, 2, 4, 0);
    vec("ovf_x511", 511, 0, 11'h7FF, 0, 2, 4, 0);
    vec("ovf_y511", 0, 511, 0, 11'h7FF, 4, 2, 0);

    // Register: toggle 0 -> 1 -> 0 -> 1
    vec("tog0", 4, 0, 5, 0, 8, 4, 0);
    vec("tog1", 2, 0, 5, 0, 8, 4, 0);
    vec("tog2", 4, 0, 5, 0, 8, 4, 0);
    vec("tog3", 2, 0, 5, 0, 8, 4, 0);

    // Reset mid-operation: combinational output stays live
    vec("rst_a", 2, 0, 5, 0, 8, 4, 1);
    vec("rst_b", 2, 0, 5, 0, 8, 4, 1);
    vec("rst_c", 2, 0, 5, 0, 8, 4, 0);
    vec("rst_d", 2, 0, 5, 0, 8, 4, 0);
    @(negedge clk);
    check_bit("rst_recover_r", dest_enable_r, 1'b1);

    // Random stimulus near block boundaries
    for (int i = 0; i < 60; i++) begin
      vec("rand",
          9'($urandom_range(0, 20)), 9'($urandom_range(0, 20)),
          11'($urandom_range(0, 70)), 11'($urandom_range(0, 70)),
          7'($urandom_range(0, 20)), 7'($urandom_range(0, 20)), 0);
    end
    for (int i = 0; i < 30; i++) begin
      vec("rand_wide",
          9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)),
          11'($urandom_range(1900, 2047)), 11'($urandom_range(1900, 2047)),
          7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)), 0);
    end

    if (exp_q.size() != 0) check_bit("queue_drained", 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
